// File: rtl/multi_timer.sv
// multi_timer: bank of independent programmable cycle timers, one-shot or
// periodic, each with a shadow configuration that loads on start or reload.
module multi_timer #(
  parameter int  CHANNELS      = 4,
  parameter int  WIDTH         = 3,
  parameter int  DEFAULT_LIMIT = 2,
  localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                tickEn,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] clrTimer,
  input  logic                wrEn,
  input  logic [CW-1:0]       wrChan,
  input  logic [WIDTH-1:0]    wrLimit,
  input  logic                wrPeriodic,
  output logic [CHANNELS-1:0] timerDone,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] expired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] limit;
    logic             periodic;
  } cfg_t;

  localparam cfg_t RESET_CFG = '{limit: WIDTH'(DEFAULT_LIMIT), periodic: 1'b0};

  state_t           state_q  [CHANNELS];
  state_t           state_d  [CHANNELS];
  logic [WIDTH-1:0] cycles_q [CHANNELS];
  logic [WIDTH-1:0] cycles_d [CHANNELS];
  cfg_t             active_q [CHANNELS];
  cfg_t             active_d [CHANNELS];
  cfg_t             shadow_q [CHANNELS];
  cfg_t             shadow_d [CHANNELS];

  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] terminal;
  cfg_t                wr_cfg;

  assign wr_cfg = '{limit: wrLimit, periodic: wrPeriodic};

  // Addresses at or beyond CHANNELS match no channel, so such writes fall away.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++)
      wr_hit[i] = wrEn && (wrChan == CW'(i));
  end

  always_comb begin
    terminal = '0;
    for (int i = 0; i < CHANNELS; i++)
      terminal[i] = (state_q[i] == RUN) && (cycles_q[i] == active_q[i].limit) &&
                    tickEn && !clrTimer[i];
  end

  // NOTE: every target gets its hold value before any branch; a path that
  // skips an assignment in always_comb would otherwise infer a latch.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      cycles_d[i] = cycles_q[i];
      active_d[i] = active_q[i];
      // A write landing with a start or reload is what gets loaded.
      shadow_d[i] = wr_hit[i] ? wr_cfg : shadow_q[i];

      if (clrTimer[i]) begin
        state_d[i]  = IDLE;
        cycles_d[i] = '0;
      end else if (start[i]) begin
        state_d[i]  = RUN;
        cycles_d[i] = '0;
        active_d[i] = shadow_d[i];
      end else if (terminal[i]) begin
        cycles_d[i] = '0;
        if (active_q[i].periodic) active_d[i] = shadow_d[i];
        else                      state_d[i]  = HOLD;
      end else if ((state_q[i] == RUN) && tickEn) begin
        cycles_d[i] = cycles_q[i] + WIDTH'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every channel sees
  // the pre-edge values of all registers, independent of statement order.
  // The per-channel arrays are small flop banks, not RAM, so they take reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= IDLE;
        cycles_q[i] <= '0;
        active_q[i] <= RESET_CFG;
        shadow_q[i] <= RESET_CFG;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= state_d[i];
        cycles_q[i] <= cycles_d[i];
        active_q[i] <= active_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  always_comb begin
    busy    = '0;
    expired = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      busy[i]    = (state_q[i] == RUN);
      expired[i] = (state_q[i] == HOLD);
    end
  end

  assign timerDone = terminal;

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised bank of independent cycle timers, the multi-channel successor to the single fixed-terminal cycle counter. Each channel counts enabled clock ticks up to a programmable limit and raises a one-cycle `timerDone` pulse, in either one-shot or periodic mode. It sits beside the control FSMs that need timeouts and replaces hand-instantiated fixed counters.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent timer channels (1..16).
- `WIDTH`, 3: counter and limit width in bits (2..32).
- `DEFAULT_LIMIT`, 2: reset value of every channel's limit (must fit in `WIDTH`).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rstN`  in  1: asynchronous, active-low reset.
- `tickEn`  in  1: global count enable; counters advance only in cycles where it is 1.
- `start`  in  CHANNELS: per-channel start/restart request.
- `clrTimer`  in  CHANNELS: per-channel abort and clear.
- `wrEn`  in  1: configuration write strobe.
- `wrChan`  in  $clog2(CHANNELS) (min 1): channel addressed by the write.
- `wrLimit`  in  WIDTH: limit value to write.
- `wrPeriodic`  in  1: mode to write; 1 = periodic, 0 = one-shot.
- `timerDone`  out  CHANNELS: one-cycle terminal pulse per channel.
- `busy`  out  CHANNELS: channel in RUN.
- `expired`  out  CHANNELS: one-shot channel finished, held until cleared or restarted.

## Operation
- Per-channel state: `cycles` (WIDTH), active `limit`, active `periodic`, shadow `limit`/`periodic`, FSM {IDLE, RUN, HOLD}.
- Reset: all channels IDLE, `cycles`=0, active and shadow limit = DEFAULT_LIMIT, mode one-shot. `timerDone`, `busy` and `expired` are all 0.
- `timerDone[i]` is combinational: RUN && `cycles`==`limit` && `tickEn` && !`clrTimer[i]`.
- Per-channel priority, highest first:
  1. `clrTimer`: go to IDLE, `cycles`<=0. Active config is unchanged.
  2. `start`, from any state: copy shadow into active config, `cycles`<=0, go to RUN.
  3. In RUN with `timerDone`: `cycles`<=0. If periodic, copy shadow into active config and stay in RUN. If one-shot, go to HOLD.
  4. In RUN with `tickEn` and no terminal: `cycles`<=`cycles`+1.
  5. Otherwise hold.
- Config write: if `wrEn` and `wrChan`<CHANNELS, the shadow config of that channel is written. The write never alters the active config of a running count. Writes with `wrChan`≥CHANNELS are ignored.
- If a write and a start/reload hit the same channel in the same cycle, the newly written value is the one loaded.
- `busy` = state==RUN. `expired` = state==HOLD. Both are registered-state decodes.
- The counter never exceeds `limit`, so no wrap occurs. `limit`=0 gives a pulse on every enabled tick.
- Channels are fully independent. The only shared inputs are `tickEn` and the write port.

## Timing
- Latency from `start` sampled at edge E0 to `timerDone`: the pulse appears in the cycle after the `limit`-th enabled tick, counting the cycles after E0. With `tickEn`=1 constantly, `timerDone` is high in the cycle following edge E0+`limit`.
- Periodic period = `limit`+1 enabled ticks. DEFAULT_LIMIT=2 gives a pulse every 3rd cycle, matching the legacy timer.
- Start coinciding with terminal: `timerDone` still pulses that cycle, then the channel restarts at 0 in RUN (not HOLD).
- Clear coinciding with terminal: no pulse; the channel goes to IDLE.
- `tickEn` low: counting freezes and no pulses occur. Start and clear still act.
- Asynchronous reset mid-count: all outputs drop to 0 immediately, with no pulse. The first `start` is accepted on the first edge after `rstN` deasserts.

## Test plan
- Reset defaults: after `rstN` release, `start[0]` once with `tickEn`=1 → `busy[0]`=1; `timerDone[0]` high exactly 2 cycles after the start edge; then `expired[0]`=1 and `busy[0]`=0, holding until `clrTimer[0]` → IDLE.
- Periodic: write ch1 limit 5, periodic; `start[1]` → `timerDone[1]` every 6 cycles for at least 4 periods; other channels stay idle with all outputs 0.
- Shadow config: ch2 periodic with limit 3 running; write limit 1 mid-period → current period still ends after 4 cycles; subsequent periods are 2 cycles.
- `tickEn` gating: ch0 limit 4, `tickEn` toggling 1/0 every cycle → pulse lands after 4 enabled ticks (about 8 cycles). No pulse occurs while `tickEn`=0.
- Collisions: start and terminal in the same cycle → pulse, then restart. Clear and terminal in the same cycle → no pulse, IDLE. Write with `wrChan`=CHANNELS → no channel changes.
- Async reset mid-count on all 4 channels running → all outputs 0 within the reset assertion, with no clock edge required.
